comparator_seq_ctrl: RTL and testbench
======================================

COMPARATOR_SEQ_CTRL -- requirements
Module: comparator_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; even, >= 2.
REQ-002 Derived SLICES = WIDTH/2, the number of 2-bit slices; CW = clog2(SLICES)+1.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand pair a_in/b_in is valid.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 a_in  input  WIDTH  operand A, unsigned.
REQ-009 b_in  input  WIDTH  operand B, unsigned.
REQ-010 out_valid  output  1  result flags are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 agtb  output  1  A > B.
REQ-013 aeqb  output  1  A == B.
REQ-014 altb  output  1  A < B.
REQ-015 slices_used  output  CW  number of slices examined for the current result, 1..SLICES.
REQ-016 busy  output  1  high in the COMPARE and DONE states.

Function
REQ-017 The block SHALL implement the FSM states IDLE, COMPARE and DONE.
REQ-018 in_ready SHALL be 1 if and only if the state is IDLE; it is decoded combinationally from the state.
REQ-019 On a rising edge with in_valid && in_ready, the block SHALL:
- capture a_in and b_in into internal registers;
- set the slice index to SLICES-1 and the slice counter to 0;
- enter COMPARE.
REQ-020 In COMPARE, the block SHALL compare one 2-bit slice per cycle, MSB slice first: bits [2i+1:2i] of the captured A against the same bits of the captured B.
REQ-021 Slice compare rules:
- gt = A1·B1' + A0·B1'·B0' + A1·A0·B0'
- lt = A1'·B1 + A0'·B1·B0 + A1'·A0'·B0
- eq = neither gt nor lt
REQ-022 If a slice is unequal, on that edge the block SHALL:
- latch agtb or altb accordingly;
- set slices_used to the count of slices examined, including this one;
- enter DONE (early termination).
REQ-023 If a slice is equal and the index is 0, on that edge the block SHALL latch aeqb=1, set slices_used=SLICES and enter DONE.
REQ-024 If a slice is equal and the index is > 0, the block SHALL decrement the index, increment the counter and stay in COMPARE.
REQ-025 Latency: out_valid SHALL rise exactly slices_used rising edges after the accepting edge (minimum 1, maximum SLICES).
REQ-026 In DONE, out_valid SHALL be 1, and exactly one of agtb/aeqb/altb SHALL be 1.
REQ-027 The flags and slices_used SHALL be held stable in DONE until the edge where out_valid && out_ready is true; that edge returns the FSM to IDLE.
REQ-028 When out_valid is 0, agtb, aeqb, altb and slices_used SHALL all be 0.
REQ-029 Changes on a_in, b_in or in_valid outside IDLE SHALL be ignored; only the captured operands are used.
REQ-030 With out_ready held at 1, a new pair SHALL be acceptable on the edge after the DONE->IDLE edge, so there is one IDLE cycle between results.
REQ-031 out_ready asserted while out_valid is 0 SHALL have no effect.

Reset
REQ-032 While rst_n=0, the block SHALL immediately (without waiting for clk) set:
- state = IDLE, so in_ready=1;
- out_valid=0 and agtb=aeqb=altb=0;
- slices_used=0, busy=0;
- captured operands, index and counter cleared.
REQ-033 Reset asserted mid-COMPARE or in DONE SHALL abort the operation, with no result produced; after rst_n is released the block SHALL behave as freshly reset.

Verification (WIDTH=8)
REQ-034 A=0xC3, B=0x43 accepted -> out_valid after 1 edge, agtb=1, slices_used=1.
REQ-035 A=0x5A, B=0x5A -> out_valid after 4 edges, aeqb=1, slices_used=4; busy=1 throughout.
REQ-036 A=0x12, B=0x13 -> out_valid after 4 edges, altb=1, slices_used=4; a_in/b_in changed to 0xFF during COMPARE -> result unchanged.
REQ-037 Backpressure: result altb, out_ready=0 for 5 cycles -> out_valid and the flags are held constant, in_ready=0; out_ready=1 -> IDLE next edge, flags 0.
REQ-038 rst_n pulsed low during COMPARE (A=0x00, B=0x01) -> all outputs 0 asynchronously, in_ready=1; no out_valid occurs afterwards.
REQ-039 Back-to-back with out_ready=1 and in_valid=1, pairs (0x80,0x7F) then (0x01,0x02) -> gt then lt results in order, with one IDLE cycle between them.

Source files
------------

// File: rtl/comparator_seq_ctrl.sv
// ============================================================================
// comparator_seq_ctrl
//
// Sequential magnitude comparator for two unsigned WIDTH-bit operands.
// It compares the operands one 2-bit slice per clock, starting with the most
// significant slice. It stops at the first unequal slice. The result is held
// on a valid/ready output handshake until the consumer takes it.
//
// Parameters
//   WIDTH        operand width in bits; must be even and >= 2
//
// Ports
//   clk          single clock; all state changes occur on its rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     a_in/b_in hold a valid operand pair
//   in_ready     block can accept an operand pair (high only in IDLE)
//   a_in         operand A, unsigned
//   b_in         operand B, unsigned
//   out_valid    result flags are valid (high only in DONE)
//   out_ready    consumer accepts the result
//   agtb         A > B
//   aeqb         A == B
//   altb         A < B
//   slices_used  number of slices examined for this result, 1..SLICES
//   busy         high while comparing or holding a result
// ============================================================================
module comparator_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SLICES = WIDTH / 2,
    parameter int CW     = $clog2(SLICES) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          agtb,
    output logic          aeqb,
    output logic          altb,
    output logic [CW-1:0] slices_used,
    output logic          busy
);

    // The slice index needs at least one bit. This keeps WIDTH=2 legal:
    // in that case SLICES=1 and $clog2(1)=0.
    localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

    localparam logic [IW-1:0] LAST_IDX    = IW'(SLICES - 1);
    localparam logic [CW-1:0] SLICES_CW   = CW'(SLICES);
    localparam logic [CW-1:0] ONE_CW      = CW'(1);
    localparam logic [IW-1:0] ONE_IW      = IW'(1);
    localparam logic [IW-1:0] ZERO_IW     = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Captured operands and the walk through the slices
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;

    // Result registers. They are non-zero only while in DONE.
    logic             agtb_r;
    logic             aeqb_r;
    logic             altb_r;
    logic [CW-1:0]    used_r;

    // Current slice and its compare result
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [1:0]       a_sl;
    logic [1:0]       b_sl;
    logic             slice_gt;
    logic             slice_lt;
    logic             slice_eq;
    logic             accept;
    logic             release_res;

    // Handshake events. Both are qualified by the state, so in_valid is
    // ignored outside IDLE and out_ready is ignored outside DONE.
    assign accept      = (state == IDLE) && in_valid;
    assign release_res = (state == DONE) && out_ready;

    // Select the active slice by shifting the captured operands right by
    // 2*idx. The 2-bit compare then always looks at bits [1:0].
    always_comb begin
        a_shift = a_reg >> {idx, 1'b0};
        b_shift = b_reg >> {idx, 1'b0};
        a_sl    = a_shift[1:0];
        b_sl    = b_shift[1:0];
    end

    // 2-bit magnitude compare written as explicit sum-of-products terms.
    // Equality is whatever is neither greater nor less.
    always_comb begin
        slice_gt = (a_sl[1] & ~b_sl[1])
                 | (a_sl[0] & ~b_sl[1] & ~b_sl[0])
                 | (a_sl[1] &  a_sl[0] & ~b_sl[0]);
        slice_lt = (~a_sl[1] &  b_sl[1])
                 | (~a_sl[0] &  b_sl[1] &  b_sl[0])
                 | (~a_sl[1] & ~a_sl[0] &  b_sl[0]);
        slice_eq = ~slice_gt & ~slice_lt;
    end

    // State register. Reset forces IDLE immediately, which aborts any
    // comparison in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic:
    //   IDLE    -> COMPARE on an accepted pair
    //   COMPARE -> DONE on the first unequal slice, or after the last slice
    //   DONE    -> IDLE once the consumer takes the result
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = COMPARE;
                end
            end
            COMPARE: begin
                if (!slice_eq || (idx == ZERO_IW)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture and slice walk. The index counts down from the MSB
    // slice. The counter counts the slices already found equal, so
    // cnt+1 is the number of slices examined when an unequal one appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            a_reg <= a_in;
            b_reg <= b_in;
            idx   <= LAST_IDX;
            cnt   <= '0;
        end else if ((state == COMPARE) && slice_eq && (idx != ZERO_IW)) begin
            idx   <= idx - ONE_IW;
            cnt   <= cnt + ONE_CW;
        end
    end

    // Result registers. They are loaded on the edge that ends the compare
    // and cleared on the edge that hands the result over. This keeps them
    // constant for the whole DONE period and zero everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            agtb_r <= 1'b0;
            aeqb_r <= 1'b0;
            altb_r <= 1'b0;
            used_r <= '0;
        end else if (state == COMPARE) begin
            if (slice_gt) begin
                agtb_r <= 1'b1;
                used_r <= cnt + ONE_CW;
            end else if (slice_lt) begin
                altb_r <= 1'b1;
                used_r <= cnt + ONE_CW;
            end else if (idx == ZERO_IW) begin
                aeqb_r <= 1'b1;
                used_r <= SLICES_CW;
            end
        end else if (release_res) begin
            agtb_r <= 1'b0;
            aeqb_r <= 1'b0;
            altb_r <= 1'b0;
            used_r <= '0;
        end
    end

    // Output decode. The handshake and status signals come straight from
    // the state. The result outputs are also gated by out_valid, so they
    // can never show a value outside DONE.
    always_comb begin
        in_ready    = (state == IDLE);
        out_valid   = (state == DONE);
        busy        = (state == COMPARE) || (state == DONE);
        agtb        = out_valid & agtb_r;
        aeqb        = out_valid & aeqb_r;
        altb        = out_valid & altb_r;
        slices_used = out_valid ? used_r : '0;
    end

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// ============================================================================
// tb_comparator_seq_ctrl
//
// Directed testbench for comparator_seq_ctrl with WIDTH=8 (4 slices).
// Each scenario task drives its own stimulus and checks hand-computed
// expected values. Outputs are sampled 1 ns after the rising clock edge.
// ============================================================================
module tb_comparator_seq_ctrl;

    localparam int WIDTH  = 8;
    localparam int SLICES = WIDTH / 2;
    localparam int CW     = $clog2(SLICES) + 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic             agtb;
    logic             aeqb;
    logic             altb;
    logic [CW-1:0]    slices_used;
    logic             busy;

    int n_cmp;
    int n_bad;

    comparator_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .agtb        (agtb),
        .aeqb        (aeqb),
        .altb        (altb),
        .slices_used (slices_used),
        .busy        (busy)
    );

    // 10 ns clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle 1 ns before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pair in IDLE and let the accepting edge take it.
    // in_valid is dropped afterwards.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid rises.
    // The wait is bounded so a stuck DUT cannot hang the run.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (2) tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if ({agtb, aeqb, altb} !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_flags: got %b expected 000", {agtb, aeqb, altb}); end
        n_cmp++; if (slices_used !== 3'd0) begin n_bad++; $display("[TB] FAIL reset_slices_used: got %0d expected 0", slices_used); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        #2 rst_n = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    // 0xC3 vs 0x43: the MSB slice (11 vs 01) decides at once
    task automatic test_gt_early();
        int lat;
        send(8'hC3, 8'h43);
        wait_result(lat);
        n_cmp++; if (lat != 1) begin n_bad++; $display("[TB] FAIL gt_latency: got %0d expected 1", lat); end
        n_cmp++; if ({agtb, aeqb, altb} !== 3'b100) begin n_bad++; $display("[TB] FAIL gt_flags: got %b expected 100", {agtb, aeqb, altb}); end
        n_cmp++; if (slices_used !== 3'd1) begin n_bad++; $display("[TB] FAIL gt_slices_used: got %0d expected 1", slices_used); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL gt_in_ready: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL gt_release_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL gt_release_in_ready: got %b expected 1", in_ready); end
    endtask

    // 0x5A vs 0x5A: all four slices are equal, so the full latency is seen.
    // busy is checked on every cycle of the operation.
    task automatic test_equal();
        int lat;
        int busy_low;
        busy_low = 0;
        send(8'h5A, 8'h5A);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (busy !== 1'b1) busy_low++;
            tick();
            lat++;
        end
        if (busy !== 1'b1) busy_low++;
        n_cmp++; if (busy_low != 0) begin n_bad++; $display("[TB] FAIL eq_busy: got %0d low cycles expected 0", busy_low); end
        n_cmp++; if (lat != 4) begin n_bad++; $display("[TB] FAIL eq_latency: got %0d expected 4", lat); end
        n_cmp++; if ({agtb, aeqb, altb} !== 3'b010) begin n_bad++; $display("[TB] FAIL eq_flags: got %b expected 010", {agtb, aeqb, altb}); end
        n_cmp++; if (slices_used !== 3'd4) begin n_bad++; $display("[TB] FAIL eq_slices_used: got %0d expected 4", slices_used); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL eq_busy_idle: got %b expected 0", busy); end
    endtask

    // 0x12 vs 0x13: decided only by the last slice (10 vs 11).
    // The inputs are scrambled during COMPARE, and out_ready is held high
    // the whole time. out_ready must have no effect before out_valid.
    task automatic test_ignore_inputs();
        int lat;
        send(8'h12, 8'h13);
        a_in      = 8'hFF;
        b_in      = 8'hFF;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        wait_result(lat);
        in_valid = 1'b0;
        n_cmp++; if (lat != 4) begin n_bad++; $display("[TB] FAIL ign_latency: got %0d expected 4", lat); end
        n_cmp++; if ({agtb, aeqb, altb} !== 3'b001) begin n_bad++; $display("[TB] FAIL ign_flags: got %b expected 001", {agtb, aeqb, altb}); end
        n_cmp++; if (slices_used !== 3'd4) begin n_bad++; $display("[TB] FAIL ign_slices_used: got %0d expected 4", slices_used); end
        tick();
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL ign_back_idle: got %b expected 1", in_ready); end
    endtask

    // Hold back the consumer for 5 cycles. The result must stay put.
    task automatic test_backpressure();
        int lat;
        int unstable;
        unstable = 0;
        send(8'h12, 8'h13);
        wait_result(lat);
        n_cmp++; if (lat != 4) begin n_bad++; $display("[TB] FAIL bp_latency: got %0d expected 4", lat); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || {agtb, aeqb, altb} !== 3'b001 ||
                slices_used !== 3'd4 || in_ready !== 1'b0) unstable++;
        end
        n_cmp++; if (unstable != 0) begin n_bad++; $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", unstable); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_release_valid: got %b expected 0", out_valid); end
        n_cmp++; if ({agtb, aeqb, altb} !== 3'b000) begin n_bad++; $display("[TB] FAIL bp_release_flags: got %b expected 000", {agtb, aeqb, altb}); end
        n_cmp++; if (slices_used !== 3'd0) begin n_bad++; $display("[TB] FAIL bp_release_used: got %0d expected 0", slices_used); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    endtask

    // Pulse reset between clock edges during COMPARE. The outputs must clear
    // immediately, and the aborted operation must never produce a result.
    task automatic test_reset_mid();
        int seen;
        seen = 0;
        send(8'h00, 8'h01);
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if ({out_valid, agtb, aeqb, altb, slices_used} !== 7'd0) begin n_bad++; $display("[TB] FAIL rmid_outputs: got %b expected 0", {out_valid, agtb, aeqb, altb, slices_used}); end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("[TB] FAIL rmid_no_result: got %0d valid cycles expected 0", seen); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_idle: got %b expected 1", in_ready); end
    endtask

    // Two pairs with in_valid and out_ready both held high. Expect gt, then
    // one IDLE cycle, then lt.
    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b1;
        a_in      = 8'h80;
        b_in      = 8'h7F;
        in_valid  = 1'b1;
        tick();
        tick();
        n_cmp++; if ({out_valid, agtb, aeqb, altb} !== 4'b1100) begin n_bad++; $display("[TB] FAIL b2b_first: got %b expected 1100", {out_valid, agtb, aeqb, altb}); end
        n_cmp++; if (slices_used !== 3'd1) begin n_bad++; $display("[TB] FAIL b2b_first_used: got %0d expected 1", slices_used); end
        a_in = 8'h01;
        b_in = 8'h02;
        tick();
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("[TB] FAIL b2b_gap: got %b expected 01", {out_valid, in_ready}); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_second_accept: got %b expected 1", busy); end
        wait_result(lat);
        n_cmp++; if (lat != 4) begin n_bad++; $display("[TB] FAIL b2b_second_latency: got %0d expected 4", lat); end
        n_cmp++; if ({agtb, aeqb, altb} !== 3'b001) begin n_bad++; $display("[TB] FAIL b2b_second_flags: got %b expected 001", {agtb, aeqb, altb}); end
        n_cmp++; if (slices_used !== 3'd4) begin n_bad++; $display("[TB] FAIL b2b_second_used: got %0d expected 4", slices_used); end
        tick();
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_end_idle: got %b expected 1", in_ready); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        $display("[TB] starting comparator_seq_ctrl tests");
        test_reset();
        test_gt_early();
        test_equal();
        test_ignore_inputs();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
